// File: rtl/prog_truth_table_eval_if.sv
// Stream handshake bundle for the programmable truth-table gate:
// an input vector channel and a result channel.
interface prog_truth_table_eval_if #(
  parameter int N_IN = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_data;
  logic [N_IN-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/prog_truth_table_eval.sv
// Runtime-loadable N-input truth-table gate with a single registered,
// handshaked output stage and a sweep mode that streams every table entry.
module prog_truth_table_eval #(
  parameter int                      N_IN     = 3,
  parameter logic [(2**N_IN)-1:0]    RESET_TT = 8'h87
) (
  input  logic                       clk,
  input  logic                       rst_n,
  prog_truth_table_eval_if.slave     bus,
  input  logic                       cfg_shift,
  input  logic                       cfg_sin,
  input  logic                       cfg_commit,
  input  logic                       sweep_start,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic [(2**N_IN)-1:0]       tt_active
);
  localparam int TT_W = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [TT_W-1:0]   tt_active_r;
  logic [TT_W-1:0]   shadow_r;
  logic [TT_W-1:0]   pend_tt_r;
  logic              pend_r;
  logic [TT_W-1:0]   snap_tt_r;
  logic [N_IN:0]     cnt_r;
  logic              out_valid_r;
  logic              out_data_r;
  logic [N_IN-1:0]   out_idx_r;
  logic              sweep_busy_r;
  logic              sweep_done_r;

  logic              slot_free_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              beat_load_s;
  logic              sweep_last_s;
  logic [TT_W-1:0]   shadow_next_s;
  logic [TT_W-1:0]   pend_tt_next_s;
  logic              pend_next_s;

  // Entry for vector v sits at bit TT_W-1-v, which is the bitwise inverse of v.
  function automatic logic tt_lookup(input logic [TT_W-1:0] tt, input logic [N_IN-1:0] v);
    tt_lookup = tt[~v];
  endfunction

  // Handshake qualifiers, next shadow value and next pending-commit value.
  always_comb begin
    slot_free_s  = !out_valid_r || bus.out_ready;
    in_ready_s   = (state_r == IDLE) && slot_free_s;
    accept_s     = in_ready_s && bus.in_valid && !sweep_start;
    // cnt_r MSB set means every sweep beat has already been loaded.
    beat_load_s  = (state_r == SWEEP) && slot_free_s && !cnt_r[N_IN];
    sweep_last_s = (state_r == SWEEP) && cnt_r[N_IN] && out_valid_r && bus.out_ready;
    if (cfg_shift) begin
      shadow_next_s = {shadow_r[TT_W-2:0], cfg_sin};
    end else begin
      shadow_next_s = shadow_r;
    end
    if (cfg_commit) begin
      pend_tt_next_s = shadow_next_s;
      pend_next_s    = 1'b1;
    end else begin
      pend_tt_next_s = pend_tt_r;
      pend_next_s    = pend_r;
    end
  end

  // Table registers, output stage and sweep FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      tt_active_r  <= RESET_TT;
      shadow_r     <= RESET_TT;
      pend_tt_r    <= RESET_TT;
      pend_r       <= 1'b0;
      snap_tt_r    <= RESET_TT;
      cnt_r        <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 1'b0;
      out_idx_r    <= '0;
      sweep_busy_r <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      shadow_r <= shadow_next_s;

      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= tt_lookup(tt_active_r, bus.in_data);
        out_idx_r   <= bus.in_data;
      end else if (beat_load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= tt_lookup(snap_tt_r, cnt_r[N_IN-1:0]);
        out_idx_r   <= cnt_r[N_IN-1:0];
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          sweep_done_r <= 1'b0;
          if (cfg_commit) begin
            tt_active_r <= shadow_next_s;
          end
          if (sweep_start) begin
            state_r      <= SWEEP;
            sweep_busy_r <= 1'b1;
            snap_tt_r    <= tt_active_r;
            cnt_r        <= '0;
          end
        end
        SWEEP: begin
          pend_r    <= pend_next_s;
          pend_tt_r <= pend_tt_next_s;
          if (beat_load_s) begin
            cnt_r <= cnt_r + {{N_IN{1'b0}}, 1'b1};
          end
          if (sweep_last_s) begin
            state_r      <= DONE;
            sweep_busy_r <= 1'b0;
            sweep_done_r <= 1'b1;
          end
        end
        DONE: begin
          // A commit arriving in this very cycle still lands before returning to IDLE.
          if (pend_next_s) begin
            tt_active_r <= pend_tt_next_s;
          end
          pend_r       <= 1'b0;
          sweep_done_r <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          sweep_busy_r <= 1'b0;
          sweep_done_r <= 1'b0;
          pend_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;
  assign sweep_busy    = sweep_busy_r;
  assign sweep_done    = sweep_done_r;
  assign tt_active     = tt_active_r;
endmodule

// File: tb/tb_prog_truth_table_eval.sv
// Bench for prog_truth_table_eval: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the gate.
module tb_prog_truth_table_eval;
  localparam int N_IN = 3;
  localparam int TT_W = 8;

  logic clk;
  logic rst_n;
  logic cfg_shift;
  logic cfg_sin;
  logic cfg_commit;
  logic sweep_start;
  logic sweep_busy;
  logic sweep_done;
  logic [TT_W-1:0] tt_active;

  int n_checks = 0;
  int n_fail   = 0;

  prog_truth_table_eval_if #(.N_IN(N_IN)) bus ();

  prog_truth_table_eval #(.N_IN(N_IN), .RESET_TT(8'h87)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cfg_shift   (cfg_shift),
    .cfg_sin     (cfg_sin),
    .cfg_commit  (cfg_commit),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .tt_active   (tt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 sweeping, 2 done.
  int m_mode;
  int m_tt;
  int m_shadow;
  int m_pend_tt;
  bit m_pend;
  int m_snap;
  int m_next;
  bit m_ov;
  int m_od;
  int m_oi;

  function automatic int tt_bit(input int t, input int v);
    return (t >> (TT_W - 1 - v)) & 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tt = 'h87; m_shadow = 'h87; m_pend_tt = 'h87; m_pend = 1'b0;
    m_snap = 'h87; m_next = 0; m_ov = 1'b0; m_od = 0; m_oi = 0;
  endtask

  task automatic check_outputs();
    bit exp_ready;
    exp_ready = (m_mode == 0) && (!m_ov || bus.out_ready);
    check_eq("in_ready",   32'(bus.in_ready),  32'(exp_ready));
    check_eq("out_valid",  32'(bus.out_valid), 32'(m_ov));
    check_eq("out_data",   32'(bus.out_data),  32'(m_od));
    check_eq("out_idx",    32'(bus.out_idx),   32'(m_oi));
    check_eq("sweep_busy", 32'(sweep_busy),    32'(m_mode == 1));
    check_eq("sweep_done", 32'(sweep_done),    32'(m_mode == 2));
    check_eq("tt_active",  32'(tt_active),     32'(m_tt));
  endtask

  task automatic model_step(input bit iv, input int id, input bit ordy,
                            input bit ss, input bit sh, input bit sin, input bit cm);
    bit slot, acc, beat, last;
    int nsh, old_tt;
    slot   = !m_ov || ordy;
    acc    = (m_mode == 0) && slot && iv && !ss;
    beat   = (m_mode == 1) && slot && (m_next < TT_W);
    last   = (m_mode == 1) && (m_next == TT_W) && m_ov && ordy;
    nsh    = sh ? ((m_shadow * 2 + int'(sin)) % 256) : m_shadow;
    old_tt = m_tt;
    if (acc) begin
      m_ov = 1'b1; m_od = tt_bit(old_tt, id); m_oi = id;
    end else if (beat) begin
      m_ov = 1'b1; m_od = tt_bit(m_snap, m_next); m_oi = m_next; m_next++;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (m_mode == 0) begin
      if (cm) m_tt = nsh;
      if (ss) begin m_mode = 1; m_snap = old_tt; m_next = 0; end
    end else begin
      if (cm) begin m_pend = 1'b1; m_pend_tt = nsh; end
      if (m_mode == 2) begin
        if (m_pend) m_tt = m_pend_tt;
        m_pend = 1'b0;
        m_mode = 0;
      end else if (last) begin
        m_mode = 2;
      end
    end
    m_shadow = nsh;
  endtask

  // One clock: drive at negedge, check shortly after, advance model and clock.
  task automatic cyc(input bit iv, input int id, input bit ordy,
                     input bit ss, input bit sh, input bit sin, input bit cm);
    bus.in_valid = iv;
    bus.in_data  = id[N_IN-1:0];
    bus.out_ready = ordy;
    sweep_start = ss;
    cfg_shift   = sh;
    cfg_sin     = sin;
    cfg_commit  = cm;
    #1;
    check_outputs();
    model_step(iv, id, ordy, ss, sh, sin, cm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_table(input int t);
    for (int i = TT_W - 1; i >= 0; i--) cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'(((t >> i) & 1)), 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_shift = 1'b0; cfg_sin = 1'b0; cfg_commit = 1'b0; sweep_start = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Full table readout of the reset table at full throughput.
    for (int v = 0; v < TT_W; v++) cyc(1'b1, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reprogram to 8'h69 and evaluate two vectors.
    load_table('h69);
    cyc(1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure hold with 8'h87 restored.
    load_table('h87);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sweep with out_ready toggling and in_valid held high throughout.
    cyc(1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cyc(1'b1, i % 8, 1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b0);

    // Commit 8'hFF mid-sweep; the sweep keeps its snapshot.
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a sweep.
    load_table('h87);
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional sweeps, shifts, commits and one reset.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) async_reset();
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, TT_W - 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
